luma_subpel_interp: RTL and testbench

- Parametrised successor to the fixed 8-pixel horizontal subpixel interpolator.
- Performs full separable HEVC luma 8-tap interpolation of one BLK x BLK block.
- Each block uses a runtime-selected fractional position (frac_x, frac_y in quarter-pel units).
- Consumes reference rows over a valid/ready stream and emits one interpolated output row per accepted row once the vertical window is full. It sits between the reference-row fetcher and the prediction buffer.

---
 rtl/luma_subpel_interp_pkg.sv | 36 +++
 rtl/luma_subpel_interp_fir8.sv | 27 ++
 rtl/luma_subpel_interp.sv | 158 +++++++++++++++
 tb/tb_luma_subpel_interp.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/luma_subpel_interp_pkg.sv
// Shared types and constants for the separable HEVC luma 8-tap interpolator.
// Coefficient table, FSM encoding and bit-depth dependent shift helpers.
package luma_subpel_interp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_FLUSH
    } state_e;

    localparam int FILL_ROWS = 7;
    localparam int V_SHIFT   = 6;
    localparam int CNT_W     = 6;

    // Phase 0 is identity and bypassed by the caller, so its taps are zero.
    localparam logic signed [6:0] COEF [4][8] = '{
        '{ 7'sd0,  7'sd0,   7'sd0,  7'sd0,  7'sd0,   7'sd0,  7'sd0,  7'sd0},
        '{-7'sd1,  7'sd4, -7'sd10, 7'sd58, 7'sd17,  -7'sd5,  7'sd1,  7'sd0},
        '{-7'sd1,  7'sd4, -7'sd11, 7'sd40, 7'sd40, -7'sd11,  7'sd4, -7'sd1},
        '{ 7'sd0,  7'sd1,  -7'sd5, 7'sd17, 7'sd58, -7'sd10,  7'sd4, -7'sd1}
    };

    function automatic int h_shift(input int pix_w);
        return pix_w - 8;
    endfunction

    function automatic int id_shift(input int pix_w);
        return 14 - pix_w;
    endfunction

    function automatic int out_rnd(input int pix_w);
        return 1 << (13 - pix_w);
    endfunction

endpackage

// File: rtl/luma_subpel_interp_fir8.sv
// Eight-tap FIR with runtime phase select; used for both the horizontal
// (unsigned pixels) and vertical (signed intermediates) passes.
module luma_fir8
    import luma_subpel_interp_pkg::*;
#(
    parameter int IN_W      = 8,
    parameter bit IN_SIGNED = 1'b0,
    parameter int ACC_W     = 16
) (
    input  logic [8*IN_W-1:0]       x_i,
    input  logic [1:0]              phase_i,
    output logic signed [ACC_W-1:0] sum_o
);

    function automatic logic signed [ACC_W-1:0] widen(input logic [IN_W-1:0] v);
        if (IN_SIGNED) return ACC_W'(signed'(v));
        return ACC_W'(v);
    endfunction

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < 8; k++) begin
            sum_o += widen(x_i[k*IN_W +: IN_W]) * ACC_W'(COEF[phase_i][k]);
        end
    end

endmodule

// File: rtl/luma_subpel_interp.sv
// Separable HEVC luma 8-tap subpel interpolator for one BLK x BLK block.
// Horizontal pass on each incoming row, 8-row vertical window, clipped output.
module luma_subpel_interp
    import luma_subpel_interp_pkg::*;
#(
    parameter int BLK   = 8,
    parameter int PIX_W = 8,
    parameter int INT_W = PIX_W + 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 frac_x,
    input  logic [1:0]                 frac_y,
    output logic                       busy,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [(BLK+7)*PIX_W-1:0]   in_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BLK*PIX_W-1:0]       out_row,
    output logic                       out_last,
    output logic                       done
);

    localparam int ACC_V = INT_W + 8;
    localparam int HSH   = h_shift(PIX_W);
    localparam int ID_SH = id_shift(PIX_W);
    localparam int OSH   = id_shift(PIX_W);
    localparam logic signed [ACC_V-1:0] RND  = ACC_V'(out_rnd(PIX_W));
    localparam logic signed [ACC_V-1:0] PMAX = ACC_V'((1 << PIX_W) - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         fx_q, fy_q;
    logic               ov_q, last_q;
    logic [BLK*PIX_W-1:0] row_q, row_d;
    logic               accept, run_acc, fill_end, run_end;

    assign accept   = in_valid && in_ready;
    assign run_acc  = accept && (state_q == S_RUN);
    assign fill_end = (cnt_q == CNT_W'(FILL_ROWS - 1));
    assign run_end  = (cnt_q == CNT_W'(BLK - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_FILL;
            S_FILL:  if (accept && fill_end) state_d = S_RUN;
            S_RUN:   if (accept && run_end) state_d = S_FLUSH;
            S_FLUSH: if (ov_q && out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        in_ready = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE:  ;
            S_FILL:  begin busy = 1'b1; in_ready = 1'b1; end
            S_RUN:   begin busy = 1'b1; in_ready = !ov_q || out_ready; end
            S_FLUSH: begin busy = 1'b1; done = ov_q && out_ready; end
            default: ;
        endcase
    end

    // The row counter restarts at the FILL->RUN boundary so it counts outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            fx_q  <= '0;
            fy_q  <= '0;
        end else if (state_q == S_IDLE) begin
            cnt_q <= '0;
            if (start) begin
                fx_q <= frac_x;
                fy_q <= frac_y;
            end
        end else if (accept) begin
            cnt_q <= (state_q == S_FILL && fill_end) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q   <= 1'b0;
            last_q <= 1'b0;
            row_q  <= '0;
        end else if (run_acc) begin
            ov_q   <= 1'b1;
            last_q <= run_end;
            row_q  <= row_d;
        end else if (out_ready) begin
            ov_q   <= 1'b0;
            last_q <= 1'b0;
        end
    end

    assign out_valid = ov_q;
    assign out_last  = last_q;
    assign out_row   = row_q;

    for (genvar c = 0; c < BLK; c++) begin : g_col
        logic signed [INT_W-1:0] hsum, h;
        logic signed [INT_W-1:0] win_q [FILL_ROWS];
        logic [8*INT_W-1:0]      vx;
        logic signed [ACC_V-1:0] vsum, v, r;
        logic [PIX_W-1:0]        pix;

        luma_fir8 #(.IN_W(PIX_W), .IN_SIGNED(1'b0), .ACC_W(INT_W)) u_h (
            .x_i     (in_row[c*PIX_W +: 8*PIX_W]),
            .phase_i (fx_q),
            .sum_o   (hsum)
        );

        always_comb begin
            if (fx_q == 2'd0) h = INT_W'(in_row[(c+3)*PIX_W +: PIX_W]) << ID_SH;
            else              h = hsum >>> HSH;
        end

        always_ff @(posedge clk) begin
            if (accept) begin
                for (int k = 0; k < FILL_ROWS - 1; k++) win_q[k] <= win_q[k+1];
                win_q[FILL_ROWS-1] <= h;
            end
        end

        for (genvar k = 0; k < FILL_ROWS; k++) begin : g_tap
            assign vx[k*INT_W +: INT_W] = win_q[k];
        end
        assign vx[7*INT_W +: INT_W] = h;

        luma_fir8 #(.IN_W(INT_W), .IN_SIGNED(1'b1), .ACC_W(ACC_V)) u_v (
            .x_i     (vx),
            .phase_i (fy_q),
            .sum_o   (vsum)
        );

        always_comb begin
            if (fy_q == 2'd0) v = ACC_V'(win_q[3]);
            else              v = vsum >>> V_SHIFT;
            r = (v + RND) >>> OSH;
            if (r[ACC_V-1])    pix = '0;
            else if (r > PMAX) pix = '1;
            else               pix = PIX_W'(r);
        end

        assign row_d[c*PIX_W +: PIX_W] = pix;
    end

endmodule

// File: tb/tb_luma_subpel_interp.sv
// Self-checking bench: table of block vectors against a behavioural model,
// plus reset/start corner sequences and a BLK=4/16, 10-bit flat-field sweep.
module tb_luma_subpel_interp;

    localparam int B  = 8;
    localparam int PW = 8;
    localparam int NR = B + 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, start, busy, in_valid, in_ready;
    logic [1:0]        frac_x, frac_y;
    logic [NR*PW-1:0]  in_row;
    logic              out_valid, out_ready, out_last, done;
    logic [B*PW-1:0]   out_row;

    luma_subpel_interp #(.BLK(B), .PIX_W(PW)) dut (
        .clk(clk), .rst(rst), .start(start), .frac_x(frac_x), .frac_y(frac_y),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .done(done)
    );

    // Width/depth sweep instances
    logic s_start, s_iv, s_or;
    logic a_busy, a_ir, a_ov, a_last, a_done;
    logic [11*10-1:0] a_row;
    logic [4*10-1:0]  a_out;
    logic b_busy, b_ir, b_ov, b_last, b_done;
    logic [23*10-1:0] b_row;
    logic [16*10-1:0] b_out;

    luma_subpel_interp #(.BLK(4), .PIX_W(10)) dut4 (
        .clk(clk), .rst(rst), .start(s_start), .frac_x(2'd1), .frac_y(2'd2),
        .busy(a_busy), .in_valid(s_iv), .in_ready(a_ir), .in_row(a_row),
        .out_valid(a_ov), .out_ready(s_or), .out_row(a_out),
        .out_last(a_last), .done(a_done)
    );

    luma_subpel_interp #(.BLK(16), .PIX_W(10)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .frac_x(2'd3), .frac_y(2'd3),
        .busy(b_busy), .in_valid(s_iv), .in_ready(b_ir), .in_row(b_row),
        .out_valid(b_ov), .out_ready(s_or), .out_row(b_out),
        .out_last(b_last), .done(b_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // Behavioural reference: spec arithmetic on whole arrays
    int pix [NR][NR];
    int expo [B][B];

    function automatic int coefv(input int f, input int k);
        int t [4][8] = '{'{0, 0, 0, 0, 0, 0, 0, 0},
                         '{-1, 4, -10, 58, 17, -5, 1, 0},
                         '{-1, 4, -11, 40, 40, -11, 4, -1},
                         '{0, 1, -5, 17, 58, -10, 4, -1}};
        return t[f][k];
    endfunction

    task automatic model(input int fx, input int fy);
        int h [NR][B];
        int s, v, o;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < B; c++) begin
                if (fx == 0) h[r][c] = pix[r][c+3] << 6;
                else begin
                    s = 0;
                    for (int k = 0; k < 8; k++) s += coefv(fx, k) * pix[r][c+k];
                    h[r][c] = s;
                end
            end
        for (int i = 0; i < B; i++)
            for (int c = 0; c < B; c++) begin
                if (fy == 0) v = h[i+3][c];
                else begin
                    s = 0;
                    for (int k = 0; k < 8; k++) s += coefv(fy, k) * h[i+k][c];
                    v = s >>> 6;
                end
                o = (v + 32) >>> 6;
                expo[i][c] = (o < 0) ? 0 : (o > 255) ? 255 : o;
            end
    endtask

    function automatic logic [NR*PW-1:0] pack(input int r);
        logic [NR*PW-1:0] v;
        for (int j = 0; j < NR; j++) v[j*PW +: PW] = PW'(pix[r][j]);
        return v;
    endfunction

    typedef struct {
        int fx, fy, pat, bp, poke, e0, e1;
    } vec_t;
    vec_t vt[$];

    task automatic run_block(input vec_t v);
        int r, o, acc, dn, post, acc8, fov, nbad;
        bit held;
        logic [B*PW-1:0] hrow, erow;
        bit pat4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NR; j++)
                case (v.pat)
                    0: pix[i][j] = 100;
                    1: pix[i][j] = 10 * i + j;
                    2: pix[i][j] = (j == 3) ? 255 : 0;
                    default: pix[i][j] = int'($urandom_range(0, 255));
                endcase
        model(v.fx, v.fy);
        @(negedge clk);
        start = 1'b1; frac_x = 2'(v.fx); frac_y = 2'(v.fy);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; frac_x = 2'($urandom); frac_y = 2'($urandom);
        #1;
        chk("busy_after_start", busy, 1);
        r = 0; o = 0; acc = 0; dn = 0; post = 0; acc8 = -1; fov = -1; held = 0;
        hrow = '0;
        for (int cyc = 0; cyc < 400 && post <= 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (v.poke != 0 && cyc == 4) begin
                start = 1'b1; frac_x = 2'(v.fx + 1); frac_y = 2'(v.fy + 2);
            end else start = 1'b0;
            in_valid  = (v.bp == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_row    = pack((r < NR) ? r : NR - 1);
            out_ready = (v.bp == 1) ? pat4[cyc % 4] :
                        (v.bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_row", int'(out_row == hrow), 1);
            end
            if (out_valid && !out_ready) chk("bp_in_ready", in_ready, 0);
            held = out_valid && !out_ready;
            hrow = out_row;
            if (in_valid && in_ready) begin
                acc++;
                if (acc == 8) acc8 = cyc;
                if (r < NR) r++;
            end
            if (out_valid && fov < 0) fov = cyc;
            if (out_valid && out_ready) begin
                if (o < B) begin
                    nbad = 0;
                    for (int c = 0; c < B; c++) erow[c*PW +: PW] = PW'(expo[o][c]);
                    checks++;
                    if (out_row !== erow) begin
                        errors++;
                        $display("FAIL out_row[%0d] fx=%0d fy=%0d act=%h exp=%h",
                                 o, v.fx, v.fy, out_row, erow);
                    end
                    if (o == 0 && v.e0 >= 0) begin
                        chk("col0", int'(out_row[0 +: PW]), v.e0);
                        chk("col1", int'(out_row[PW +: PW]), v.e1);
                    end
                end
                chk("out_last", out_last, int'(o == B - 1));
                o++;
            end
            if (done) dn++;
            if (dn > 0) post++;
        end
        if (post <= 3) begin
            errors++;
            $display("FAIL block_timeout act=%0d rows_out exp=%0d", o, B);
        end
        chk("rows_in", acc, NR);
        chk("rows_out", o, B);
        chk("done_count", dn, 1);
        chk("busy_end", busy, 0);
        if (v.pat == 1) chk("first_valid_latency", fov, acc8 + 1);
    endtask

    task automatic reset_test;
        int acc, dn;
        for (int i = 0; i < NR; i++)
            for (int j = 0; j < NR; j++) pix[i][j] = int'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b1; frac_x = 2'd1; frac_y = 2'd2; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc = 0; dn = 0;
        for (int i = 0; i < 50 && acc < 10; i++) begin
            in_valid = 1'b1;
            in_row = pack(acc);
            #1;
            if (in_ready) acc++;
            if (done) dn++;
            @(negedge clk);
        end
        chk("rst_rows_fed", acc, 10);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_no_done_before", dn, 0);
        rst = 1'b0;
    endtask

    // Sweep monitors
    int a_acc = 0, a_n = 0, a_dn = 0, b_acc = 0, b_n = 0, b_dn = 0;
    int a_bad, b_bad;

    always @(negedge clk) begin
        if (s_iv && a_ir) a_acc++;
        if (a_ov && s_or) begin
            a_bad = 0;
            for (int c = 0; c < 4; c++) if (a_out[c*10 +: 10] != 10'd1000) a_bad++;
            chk("sw4_flat", a_bad, 0);
            chk("sw4_last", a_last, int'(a_n == 3));
            a_n++;
        end
        if (a_done) a_dn++;
        if (s_iv && b_ir) b_acc++;
        if (b_ov && s_or) begin
            b_bad = 0;
            for (int c = 0; c < 16; c++) if (b_out[c*10 +: 10] != 10'd1000) b_bad++;
            chk("sw16_flat", b_bad, 0);
            chk("sw16_last", b_last, int'(b_n == 15));
            b_n++;
        end
        if (b_done) b_dn++;
    end

    task automatic sweep;
        int i;
        @(negedge clk);
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        for (i = 0; i < 200 && !(a_dn > 0 && b_dn > 0); i++) @(negedge clk);
        repeat (3) @(negedge clk);
        if (i >= 200) begin
            errors++;
            $display("FAIL sweep_timeout act=%0d,%0d exp=1,1", a_dn, b_dn);
        end
        chk("sw4_rows_in", a_acc, 11);
        chk("sw16_rows_in", b_acc, 23);
        chk("sw4_rows_out", a_n, 4);
        chk("sw16_rows_out", b_n, 16);
        chk("sw4_done", a_dn, 1);
        chk("sw16_done", b_dn, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frac_x = '0; frac_y = '0;
        in_valid = 1'b1; in_row = '0; out_ready = 1'b1;
        s_start = 1'b0; s_iv = 1'b1; s_or = 1'b1;
        for (int j = 0; j < 11; j++) a_row[j*10 +: 10] = 10'd1000;
        for (int j = 0; j < 23; j++) b_row[j*10 +: 10] = 10'd1000;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_in_ready", in_ready, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_done", done, 0);
        chk("reset_out_row_zero", int'(out_row == '0), 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 0);

        for (int fx = 0; fx < 4; fx++)
            for (int fy = 0; fy < 4; fy++)
                vt.push_back('{fx, fy, 0, 0, 0, 100, 100});
        vt.push_back('{0, 0, 1, 0, 0, 33, 34});
        vt.push_back('{0, 0, 1, 1, 0, 33, 34});
        vt.push_back('{2, 0, 2, 0, 0, 159, 0});
        vt.push_back('{2, 0, 2, 1, 0, 159, 0});
        vt.push_back('{1, 3, 3, 1, 1, -1, -1});
        vt.push_back('{0, 2, 1, 0, 1, -1, -1});
        for (int i = 0; i < 6; i++)
            vt.push_back('{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                           3, 2, 0, -1, -1});
        foreach (vt[i]) run_block(vt[i]);

        reset_test;
        run_block('{3, 1, 3, 2, 0, -1, -1});
        sweep;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
